// File: rtl/serial_pkg.sv
// Shared serial-link definitions: FSM state encoding and line levels.
// Used by both the transmit and the receive side.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_tx_if.sv
// Word handshake into the serial transmitter.
// master drives the word, slave (the transmitter) returns ready.
interface serial_tx_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] iData;
  logic              iValid;
  logic              oReady;

  modport master (
    output iData,
    output iValid,
    input  oReady
  );

  modport slave (
    input  iData,
    input  iValid,
    output oReady
  );

endinterface

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, pulses oTick
// on the wrap cycle, and is held at zero while disabled.
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic iclk,
  input  logic irstn,
  input  logic iEn,
  output logic oTick
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign oTick = iEn && (cnt == LAST);

  always_ff @(posedge iclk) begin
    if (!irstn) begin
      cnt <= '0;
    end else if (!iEn || oTick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start, LSB-first data, stop; idle high.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before stop.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        iclk,
  input  logic        irstn,
  serial_tx_if.slave  bus,
  output logic        oTx,
  output logic        oBusy
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  state_t            state, state_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic [IW-1:0]     idx, idx_n;
  logic              tx_q, tx_n;
  logic              tick;
  logic              accept;

`ifdef SERIAL_TX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
  logic par_q, par_n;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  assign bus.oReady = (state == IDLE);
  assign oBusy      = (state != IDLE);
  assign oTx        = tx_q;
  assign accept     = bus.iValid && (state == IDLE);

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .iclk  (iclk),
    .irstn (irstn),
    .iEn   (state != IDLE),
    .oTick (tick)
  );

  always_comb begin
    state_n = state;
    sh_n    = sh;
    idx_n   = idx;
    tx_n    = LINE_IDLE;
`ifdef SERIAL_TX_PARITY_EN
    par_n   = accept ? ^bus.iData : par_q;
`endif
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = START;
          sh_n    = bus.iData;
        end
      end
      START: begin
        if (tick) state_n = DATA;
      end
      DATA: begin
        if (tick) begin
          sh_n = sh >> 1;
          if (idx == LAST_IDX) begin
            idx_n   = '0;
            state_n = AFTER_DATA;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (tick) state_n = STOP;
      end
`endif
      STOP: begin
        if (tick) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Line level is registered from the next state so oTx has no comb path.
    unique case (state_n)
      START:   tx_n = START_BIT;
      DATA:    tx_n = sh_n[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  tx_n = par_n;
`endif
      STOP:    tx_n = STOP_BIT;
      default: tx_n = LINE_IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!irstn) begin
      state <= IDLE;
      sh    <= '0;
      idx   <= '0;
      tx_q  <= LINE_IDLE;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      idx   <= idx_n;
      tx_q  <= tx_n;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  always_ff @(posedge iclk) begin
    if (!irstn) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_n;
    end
  end
`endif

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: accepted words are queued and each
// captured serial frame is compared against a framing model.
module tb_serial_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB  = DW + 3;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = DW + 2;
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = NB * CPB;

  logic iclk  = 1'b0;
  logic irstn = 1'b0;
  logic oTx, oBusy;

  always #5 iclk = ~iclk;

  serial_tx_if #(.DATA_W(DW)) bus ();

  serial_tx #(
    .DATA_W       (DW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .iclk  (iclk),
    .irstn (irstn),
    .bus   (bus),
    .oTx   (oTx),
    .oBusy (oBusy)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            e;
  } exp_t;

  exp_t        sbq[$];
  exp_t        cur;
  int          n_cmp   = 0;
  int          n_err   = 0;
  int          ecount  = 0;
  int          nacc    = 0;
  int          nframes = 0;
  int          nbit    = 0;
  int          hi_run  = 0;
  int          gap     = 0;
  bit          rst_edge = 1'b0;
  bit          coll     = 1'b0;
  bit          badhs    = 1'b0;
  logic [63:0] frame    = '0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_frame(logic [DW-1:0] d);
    logic [63:0] f;
    f = '0;
    for (int c = 0; c < FL; c++) begin
      int b;
      b = c / CPB;
      if (b == 0)                   f[c] = 1'b0;
      else if (b <= DW)             f[c] = d[b-1];
      else if (PAR && b == DW + 1)  f[c] = ^d;
      else                          f[c] = 1'b1;
    end
    return f;
  endfunction

  always @(posedge iclk) begin
    ecount   <= ecount + 1;
    rst_edge <= !irstn;
    if (irstn && bus.iValid === 1'b1 && bus.oReady === 1'b1) begin
      sbq.push_back('{d: bus.iData, e: ecount + 1});
      nacc <= nacc + 1;
    end
  end

  always @(negedge iclk) begin
    if (rst_edge) begin
      if (coll) begin
        coll = 1'b0;
        if (sbq.size() > 0) cur = sbq.pop_front();
        chk("abort_tx", oTx, 1);
        chk("abort_rdy", bus.oReady, 1);
        chk("abort_busy", oBusy, 0);
      end
    end else if (coll) begin
      frame[nbit] = oTx;
      if (bus.oReady !== 1'b0 || oBusy !== 1'b1) badhs = 1'b1;
      nbit++;
      if (nbit == FL) begin
        coll    = 1'b0;
        nframes++;
        hi_run  = CPB;
        if (sbq.size() > 0) begin
          cur = sbq.pop_front();
          chk($sformatf("frame_%0h", cur.d), frame, mk_frame(cur.d));
        end
        chk("hs_in_frame", badhs, 0);
      end
    end else if (oTx === 1'b0) begin
      chk("sb_pending", sbq.size() != 0, 1);
      if (sbq.size() != 0) chk("latency", ecount - sbq[0].e, 0);
      coll     = 1'b1;
      nbit     = 1;
      frame    = '0;
      badhs    = (bus.oReady !== 1'b0 || oBusy !== 1'b1);
      gap      = hi_run;
    end else begin
      hi_run++;
    end
  end

  task automatic wait_acc();
    int k;
    bit done;
    k    = nacc;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge iclk);
      #1;
      if (nacc != k) done = 1'b1;
    end
    chk("acc_wait", done, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge iclk);
      #2;
      if (!coll && sbq.size() == 0) done = 1'b1;
    end
    chk("idle_wait", done, 1);
    chk("ready_after", bus.oReady, 1);
  endtask

  task automatic send(logic [DW-1:0] d);
    @(posedge iclk);
    #1;
    bus.iValid = 1'b1;
    bus.iData  = d;
    wait_acc();
    bus.iValid = 1'b0;
  endtask

  initial begin
    bus.iValid = 1'b0;
    bus.iData  = '0;
    irstn      = 1'b0;
    repeat (3) @(posedge iclk);
    #2;
    chk("rst_tx", oTx, 1);
    chk("rst_rdy", bus.oReady, 1);
    chk("rst_busy", oBusy, 0);
    irstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge iclk);
      #2;
      chk("idle_tx", oTx, 1);
      chk("idle_rdy", bus.oReady, 1);
      chk("idle_busy", oBusy, 0);
    end

    send(8'hA5);
    wait_idle();

    send(8'h3C);
    bus.iData = 8'hFF;
    repeat (12) @(posedge iclk);
    #1;
    bus.iValid = 1'b1;
    repeat (2) @(posedge iclk);
    #1;
    bus.iValid = 1'b0;
    wait_idle();

    @(posedge iclk);
    #1;
    bus.iValid = 1'b1;
    bus.iData  = 8'h00;
    wait_acc();
    bus.iData  = 8'hFF;
    wait_acc();
    bus.iValid = 1'b0;
    wait_idle();
    chk("b2b_gap", gap, CPB + 1);

    send(8'h55);
    repeat (17) @(posedge iclk);
    #1;
    irstn = 1'b0;
    @(posedge iclk);
    #1;
    irstn = 1'b1;
    repeat (3) @(posedge iclk);
    send(8'h81);
    wait_idle();

    send(8'h07);
    wait_idle();
    send(8'hA5);
    wait_idle();

    chk("frames", nframes, 7);
    chk("accepts", nacc, 8);
    chk("sb_left", sbq.size(), 0);
    repeat (2) @(posedge iclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Parallel-to-serial transmitter. It drives a single-wire, idle-high, LSB-first bit stream into the flop-based serial capture path.
- It accepts a DATA_W-bit word through a valid/ready handshake.
- It frames the word as one start bit (0), then DATA_W data bits, then one stop bit (1).
- Each bit is held for CLKS_PER_BIT clocks.

Parameters:
- DATA_W, 8, payload width in bits; legal range 1 or more.
- CLKS_PER_BIT, 4, clocks per serial bit; legal range 1 or more; bit-timer width is clog2(CLKS_PER_BIT), minimum 1.

Ports:
- iclk  input  1  system clock; all logic on the rising edge.
- irstn  input  1  synchronous active-low reset.
- iData  input  DATA_W  word to send; sampled only on acceptance.
- iValid  input  1  iData is valid.
- oReady  output  1  transmitter can accept a word this cycle.
- oTx  output  1  serial line, registered, idle high.
- oBusy  output  1  frame in progress.

Behaviour:
- Clock and reset (already decided): one clock, iclk; reset irstn is synchronous and active-low.
- Reset (irstn=0 at a rising edge): state=IDLE, oTx=1, oReady=1, oBusy=0, shift register=0, bit timer=0, bit index=0.
  - Reset mid-frame aborts the frame. The line is high from the next edge; no partial stop bit is sent.
- States: IDLE, START, DATA, STOP (plus PARITY under the optional feature).
- IDLE:
  - oReady=1, oBusy=0, oTx=1.
  - Acceptance occurs when iValid=1 and oReady=1 at an edge. That edge latches iData into the shift register and moves to START.
- START: oTx=0 for exactly CLKS_PER_BIT cycles, starting the cycle after acceptance (latency 1 clock), then DATA.
- DATA:
  - oTx = shift register bit 0 (LSB first).
  - Each bit is held CLKS_PER_BIT cycles. After each bit the register shifts right and the bit index increments.
  - After bit DATA_W-1, move to STOP.
- STOP: oTx=1 for CLKS_PER_BIT cycles, then IDLE.
- oReady=0 and oBusy=1 in every state except IDLE.
- Frame length is (DATA_W+2)*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
- Back-to-back transfers: iValid held high re-accepts in the first IDLE cycle. The line is therefore high for at least CLKS_PER_BIT+1 cycles between frames.
- iValid while busy is ignored (not queued). Changes to iData after acceptance have no effect.
- Bit timer counts 0 to CLKS_PER_BIT-1 and wraps. A state or bit advance happens only on the wrap cycle.
  - With CLKS_PER_BIT=1, every cycle is a wrap.
- All outputs are registered or decoded directly from registered state; there is no combinational path from iValid/iData to oTx.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - oTx = XOR of the latched word (even parity), held CLKS_PER_BIT cycles.
  - Frame length becomes (DATA_W+3)*CLKS_PER_BIT.
  - The parity bit is computed at acceptance and stored in a dedicated flop.
- Undefined: no PARITY state, no parity flop; behaviour exactly as above.

Decomposition:
- Shared package serial_pkg:
  - state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4), 3-bit state type;
  - LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1 constants.
- The package is shared with the serial receive side.
- One natural sub-module: serial_bit_timer (CLKS_PER_BIT parameter, irstn, enable input, oTick wrap pulse). Its enable is low in IDLE, holding it at 0.

Test Plan:
- Reset: hold irstn=0 for 3 cycles, then release with iValid=0 -> oTx=1, oReady=1, oBusy=0 steady for 20 cycles.
- Single frame (DATA_W=8, CLKS_PER_BIT=4, parity off): send 0xA5 -> after 1 clock, oTx shows 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); then oReady=1.
- Busy rejection: accept 0x3C, pulse iValid with 0xFF in mid-frame -> 0x3C frame unaltered, 0xFF never transmitted, oReady=0 throughout the frame.
- Back-to-back: iValid held with 0x00 then 0xFF -> two complete frames; line high for exactly 5 cycles between the last data bit of frame 1 and the start bit of frame 2.
- Reset mid-frame: assert irstn=0 during data bit 3 of 0x55 -> oTx=1, oReady=1 at the next edge; the next accepted 0x81 is sent as a clean full frame.
- With SERIAL_TX_PARITY_EN, send 0x07 -> parity bit 1 after data; frame 44 cycles. Send 0xA5 -> parity bit 0.
